// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : MIPS instruction-fetch stage. It owns the PC, makes one
//            outstanding imem request at a time and loads the IF/ID register.
// Revision : 1.0  initial release
// ============================================================================
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] pc_out,
   input  logic [31:0] pc_plus4_in,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_plus4
);

   typedef enum logic [0:0] {
      S_FETCH = 1'b0,
      S_HOLD  = 1'b1
   } state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic        if_valid_q;
   logic [31:0] if_instr_q;
   logic [31:0] if_pc_q;
   logic [31:0] if_pc4_q;
   logic [31:0] hold_instr_q;
   logic [31:0] hold_pc_q;
   logic [31:0] hold_pc4_q;

   logic [31:0] redirect_pc_d;

   // Clearing the low bits with a mask keeps every target bit in use.
   assign redirect_pc_d = redirect_target & 32'hFFFF_FFFC;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_FETCH;
         pc_q         <= RESET_PC;
         if_valid_q   <= 1'b0;
         if_instr_q   <= NOP_INSTR;
         if_pc_q      <= 32'h0000_0000;
         if_pc4_q     <= 32'h0000_0000;
         hold_instr_q <= NOP_INSTR;
         hold_pc_q    <= 32'h0000_0000;
         hold_pc4_q   <= 32'h0000_0000;
      end else if (redirect_valid) begin
         // Any response arriving with the redirect belongs to the wrong path.
         state_q      <= S_FETCH;
         pc_q         <= redirect_pc_d;
         if_valid_q   <= 1'b0;
         if_instr_q   <= NOP_INSTR;
         hold_instr_q <= NOP_INSTR;
         hold_pc_q    <= 32'h0000_0000;
         hold_pc4_q   <= 32'h0000_0000;
      end else begin
         case (state_q)
            S_FETCH: begin
               if (imem_ready) begin
                  if (!stall) begin
                     if_valid_q <= 1'b1;
                     if_instr_q <= imem_rdata;
                     if_pc_q    <= pc_q;
                     if_pc4_q   <= pc_plus4_in;
                     pc_q       <= pc_plus4_in;
                  end else begin
                     hold_instr_q <= imem_rdata;
                     hold_pc_q    <= pc_q;
                     hold_pc4_q   <= pc_plus4_in;
                     state_q      <= S_HOLD;
                  end
               end else if (!stall) begin
                  if_valid_q <= 1'b0;
               end
            end
            S_HOLD: begin
               if (!stall) begin
                  if_valid_q <= 1'b1;
                  if_instr_q <= hold_instr_q;
                  if_pc_q    <= hold_pc_q;
                  if_pc4_q   <= hold_pc4_q;
                  pc_q       <= hold_pc4_q;
                  state_q    <= S_FETCH;
               end
            end
            default: state_q <= S_FETCH;
         endcase
      end
   end

   assign pc_out      = pc_q;
   assign imem_addr   = pc_q;
   assign imem_req    = (state_q == S_FETCH) && !reset;
   assign if_valid    = if_valid_q;
   assign if_instr    = if_instr_q;
   assign if_pc       = if_pc_q;
   assign if_pc_plus4 = if_pc4_q;

endmodule
`default_nettype wire
